// File: rtl/equiv_checker.sv
// Self-running exhaustive equivalence checker: sweeps every stimulus vector into two
// implementations, compares their outputs after LAT cycles and reports a verdict.

module eq_tag_stage #(
  parameter int IN_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            vld_i,
  input  logic [IN_W-1:0] vec_i,
  output logic            vld_o,
  output logic [IN_W-1:0] vec_o
);
  logic            vld_q;
  logic [IN_W-1:0] vec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      vec_q <= '0;
    end else begin
      vld_q <= vld_i & ~flush_i;
      vec_q <= vec_i;
    end
  end

  assign vld_o = vld_q;
  assign vec_o = vec_q;
endmodule

module equiv_checker #(
  parameter int IN_W         = 3,
  parameter int OUT_W        = 1,
  parameter int LAT          = 0,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] y_ref,
  input  logic [OUT_W-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             equivalent,
  output logic [IN_W:0]    mismatch_count,
  output logic             first_fail_valid,
  output logic [IN_W-1:0]  first_fail_vec
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DW = $clog2(LAT + 1) + 1;
  localparam logic [DW-1:0]   DRN_LAST = DW'((LAT > 0) ? (LAT - 1) : 0);
  localparam logic [IN_W-1:0] STIM_MAX = '1;
  localparam logic [IN_W:0]   CNT_MAX  = {1'b1, {IN_W{1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [IN_W-1:0] stim_q, stim_d;
  logic            busy_q, busy_d, done_q, done_d, eq_q, eq_d;
  logic [IN_W:0]   cnt_q, cnt_d;
  logic            ffv_q, ffv_d;
  logic [IN_W-1:0] ffvec_q, ffvec_d;
  logic [DW-1:0]   drn_q, drn_d;

  // Tag delay line: stage 0 is the vector presented this cycle, stage LAT is compared.
  logic [LAT:0]           vld_pipe;
  logic [LAT:0][IN_W-1:0] vec_pipe;
  logic                   mismatch, stop_hit;

  assign vld_pipe[0] = (state_q == S_DRIVE);
  assign vec_pipe[0] = stim_q;

  generate
    for (genvar i = 1; i <= LAT; i++) begin : g_tag
      eq_tag_stage #(.IN_W(IN_W)) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush_i(stop_hit),
        .vld_i  (vld_pipe[i-1]),
        .vec_i  (vec_pipe[i-1]),
        .vld_o  (vld_pipe[i]),
        .vec_o  (vec_pipe[i])
      );
    end
  endgenerate

  assign mismatch = vld_pipe[LAT] && (y_ref != y_dut);
  assign stop_hit = (STOP_ON_FAIL != 0) && mismatch;

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    eq_d    = eq_q;
    cnt_d   = cnt_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    drn_d   = drn_q;
    if (mismatch) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (!ffv_q) begin
        ffv_d   = 1'b1;
        ffvec_d = vec_pipe[LAT];
      end
    end
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          stim_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          eq_d    = 1'b0;
          cnt_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
        end
      end
      S_DRIVE: begin
        if (stim_q == STIM_MAX) begin
          state_d = (LAT > 0) ? S_DRAIN : S_DONE;
          drn_d   = '0;
        end else begin
          stim_d = stim_q + 1'b1;
        end
      end
      S_DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drn_q == DRN_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (stop_hit) state_d = S_DONE;
    // Verdict includes the compare retiring on the DONE-entry edge.
    if (state_d == S_DONE && state_q != S_DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      eq_d   = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      cnt_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      cnt_q   <= cnt_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      drn_q   <= drn_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign equivalent       = eq_q;
  assign mismatch_count   = cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
endmodule

// File: doc/equiv_checker.md
Name: equiv_checker

Overview:
- Self-running, synthesizable functional-equivalence checker for two implementations of the same combinational or pipelined function, e.g. a CMOS-level model against a gate-level model.
- Drives an exhaustive stimulus sweep onto both implementations and compares their outputs, allowing for a fixed implementation latency.
- Reports a pass/fail verdict, a mismatch count and the first failing vector.
- Replaces hand-written one-vector compare benches; instantiated beside the two implementations in a wrapper or bench.

Parameters:
IN_W, 3, stimulus width; sweep covers 0 .. 2^IN_W-1
OUT_W, 1, width of each compared output bus
LAT, 0, implementation latency in clk cycles (0 = combinational)
STOP_ON_FAIL, 0, 1 = end the sweep at the first mismatch; 0 = full sweep

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a sweep when idle or done
stim  out  IN_W  stimulus vector to both implementations
y_ref  in  OUT_W  output of reference implementation
y_dut  in  OUT_W  output of implementation under check
busy  out  1  high while sweeping or draining
done  out  1  high from sweep end until next start
equivalent  out  1  valid while done; 1 = zero mismatches
mismatch_count  out  IN_W+1  mismatching vectors, saturates at 2^IN_W
first_fail_valid  out  1  high once any mismatch is recorded
first_fail_vec  out  IN_W  stimulus of first mismatch

Behaviour:
- Reset (async assert, sync release): state IDLE; stim=0, busy=0, done=0, equivalent=0, mismatch_count=0, first_fail_valid=0, first_fail_vec=0; delay line cleared.
- FSM states IDLE, DRIVE, DRAIN, DONE.
- IDLE/DONE + start=1 -> DRIVE on next edge. On that edge:
  - clear mismatch_count, first_fail_*, equivalent and done;
  - set stim=0 and busy=1.
- start is ignored in DRIVE/DRAIN.
- DRIVE: stim increments by 1 each cycle. On the cycle stim = 2^IN_W-1 is presented, the next state is DRAIN if LAT>0, else DONE. stim holds its last value after DRIVE.
- Tag delay line: LAT stages carrying {valid, vec}. The compare for vector k happens in the cycle where stim=k was presented plus LAT cycles. For LAT=0, y_ref/y_dut are compared combinationally in the same cycle stim=k is presented, and the result is registered on that edge.
- A mismatch is y_ref != y_dut, bitwise over OUT_W, on a cycle with a valid tag. Both buses are compared as given; X/Z is the implementations' problem.
- On a mismatch:
  - mismatch_count += 1, saturating;
  - if first_fail_valid=0, latch first_fail_vec=tag vec and set first_fail_valid=1.
- DRAIN: exactly LAT cycles, then DONE. The delay line is not fed in DRAIN.
- STOP_ON_FAIL=1: the first mismatch forces the next state to DONE from DRIVE or DRAIN. Tags in flight are discarded, so mismatch_count=1.
- DONE: busy=0, done=1. equivalent = (mismatch_count==0), registered on DONE entry and held.
- Total sweep length, no early stop: 2^IN_W + LAT cycles from the first DRIVE cycle to the done rise.
- rst_n low mid-sweep aborts at once to reset values; no partial verdict is kept.
- start coinciding with DONE entry is ignored. A restart needs start in a cycle where the state is already DONE.

Test Plan:
- IN_W=3, LAT=0, identical majority functions on both buses, start pulse -> stim 0..7 on 8 consecutive cycles; done rises 8 cycles after the first DRIVE cycle; equivalent=1, mismatch_count=0, first_fail_valid=0.
- IN_W=3, y_dut = y_ref XOR (stim==5) -> equivalent=0, mismatch_count=1, first_fail_vec=5.
- IN_W=3, LAT=2, both implementations registered twice -> equivalent=1; done rises 10 cycles after sweep start. Same bench with y_dut delayed 1 cycle -> equivalent=0 and mismatch_count>0.
- STOP_ON_FAIL=1, y_dut inverted for stim>=3 -> done follows the compare of vector 3; mismatch_count=1, first_fail_vec=3.
- Pulse rst_n low while stim=4 mid-sweep -> all outputs return to reset values immediately. A new start gives a clean full sweep with identical results.
- Assert start during DRIVE -> ignored; the sweep completes unchanged. A second start in DONE reruns the sweep and clears the prior counters on entry.
